fechadura_param: RTL and testbench

//  Parametrised digit-sequence lock. Each rising edge of insere samples one BCD

---
 rtl/fechadura_param.sv | 203 ++++++++++++++++++++
 tb/tb_fechadura_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fechadura_param.sv
// Parametrised digit-sequence lock with error tolerance, timed lockout and 7-seg status display.
// Optional code programming mode is compiled in with FECHADURA_PROG_EN.
module fechadura_param #(
  parameter int                     N_DIGITOS   = 6,
  parameter logic [4*N_DIGITOS-1:0] CODIGO      = 24'h590981,
  parameter int                     MAX_ERROS   = 1,
  parameter int                     LOCK_CICLOS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [4:1] numero,
  input  logic       fechar,
  input  logic       prog,
  output logic       LED,
  output logic       aberto,
  output logic       bloqueado,
  output logic [3:0] progresso,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  localparam int              CW        = (LOCK_CICLOS > 1) ? $clog2(LOCK_CICLOS) : 1;
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(LOCK_CICLOS - 1);
  localparam logic [3:0]      LAST_IDX  = 4'(N_DIGITOS - 1);
  localparam logic [2:0]      MAX_ERR   = 3'(MAX_ERROS);
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [6:0]      SEG_A     = 7'b0001000;
  localparam logic [6:0]      SEG_F     = 7'b0111000;

`ifdef FECHADURA_PROG_EN
  typedef enum logic [1:0] {ESPERA, ABERTO, FALHA, PROG} state_t;
`else
  typedef enum logic [1:0] {ESPERA, ABERTO, FALHA} state_t;
`endif

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [2:0]             erros_q, erros_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [6:0]             seg_q, seg_d;
  logic                   insere_q;
  logic                   led_q, aberto_q, bloq_q;
  logic                   ev;
  logic                   prog_hit;
  logic [3:0]             digito;
  logic [4*N_DIGITOS-1:0] code;

`ifdef FECHADURA_PROG_EN
  logic [4*N_DIGITOS-1:0] code_q, code_d;
  assign code     = code_q;
  assign prog_hit = prog && (idx_q == 4'd0) && (erros_q == 3'd0);
`else
  logic unused_prog;
  assign unused_prog = prog;
  assign code        = CODIGO;
  assign prog_hit    = 1'b0;
`endif

  assign ev = insere & ~insere_q;

  // Active-low segments ABCDEFG; codes 10..15 render as a dash.
  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    seg_glyph = 7'b0000001;
      4'd1:    seg_glyph = 7'b1001111;
      4'd2:    seg_glyph = 7'b0010010;
      4'd3:    seg_glyph = 7'b0000110;
      4'd4:    seg_glyph = 7'b1001100;
      4'd5:    seg_glyph = 7'b0100100;
      4'd6:    seg_glyph = 7'b0100000;
      4'd7:    seg_glyph = 7'b0001111;
      4'd8:    seg_glyph = 7'b0000000;
      4'd9:    seg_glyph = 7'b0000100;
      default: seg_glyph = 7'b1111110;
    endcase
  endfunction

  always_comb begin
    digito = 4'd0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_q == 4'(i)) digito = code[4*(N_DIGITOS-1-i) +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    erros_d = erros_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
`ifdef FECHADURA_PROG_EN
    code_d  = code_q;
`endif
    case (state_q)
      ESPERA: begin
        if (ev) begin
          if (prog_hit) begin
`ifdef FECHADURA_PROG_EN
            code_d[4*(N_DIGITOS-1) +: 4] = numero;
            idx_d   = 4'd1;
            seg_d   = seg_glyph(numero);
            state_d = PROG;
`endif
          end else if (numero == digito) begin
            if (idx_q == LAST_IDX) begin
              state_d = ABERTO;
              seg_d   = SEG_A;
            end else begin
              idx_d = idx_q + 4'd1;
              seg_d = seg_glyph(numero);
            end
          end else if (erros_q < MAX_ERR) begin
            erros_d = erros_q + 3'd1;
            seg_d   = seg_glyph(numero);
          end else begin
            state_d = FALHA;
            cnt_d   = CNT_LOAD;
            seg_d   = SEG_F;
          end
        end
      end
      ABERTO: begin
        if (fechar) begin
          state_d = ESPERA;
          idx_d   = 4'd0;
          erros_d = 3'd0;
          seg_d   = SEG_BLANK;
        end
      end
      FALHA: begin
        // Expiry wins over any strobe arriving in the same cycle.
        if (cnt_q == '0) begin
          state_d = ESPERA;
          idx_d   = 4'd0;
          erros_d = 3'd0;
          seg_d   = SEG_BLANK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef FECHADURA_PROG_EN
      PROG: begin
        if (ev) begin
          for (int i = 0; i < N_DIGITOS; i++) begin
            if (idx_q == 4'(i)) code_d[4*(N_DIGITOS-1-i) +: 4] = numero;
          end
          seg_d = seg_glyph(numero);
          if (idx_q == LAST_IDX) begin
            state_d = ESPERA;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`endif
      default: state_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ESPERA;
      idx_q    <= 4'd0;
      erros_q  <= 3'd0;
      cnt_q    <= '0;
      seg_q    <= SEG_BLANK;
      insere_q <= 1'b0;
      led_q    <= 1'b0;
      aberto_q <= 1'b0;
      bloq_q   <= 1'b0;
`ifdef FECHADURA_PROG_EN
      code_q   <= CODIGO;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      erros_q  <= erros_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
      insere_q <= insere;
      led_q    <= (erros_d != 3'd0);
      aberto_q <= (state_d == ABERTO);
      bloq_q   <= (state_d == FALHA);
`ifdef FECHADURA_PROG_EN
      code_q   <= code_d;
`endif
    end
  end

  assign LED                 = led_q;
  assign aberto              = aberto_q;
  assign bloqueado           = bloq_q;
  assign progresso           = idx_q;
  assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_fechadura_param.sv
// Bench for fechadura_param: vector table, multi-cycle corner sequences and a
// randomized run against a behavioural lock model.
module tb_fechadura_param;
  localparam int          N    = 6;
  localparam logic [23:0] COD  = 24'h590981;
  localparam int          MAXE = 1;
  localparam int          L    = 1000;
`ifdef FECHADURA_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SA    = 7'b0001000;
  localparam logic [6:0] SF    = 7'b0111000;
  localparam logic [6:0] DASH  = 7'b1111110;

  logic       clk = 1'b0;
  logic       reset, insere, fechar, prog;
  logic [3:0] numero;
  logic       LED, aberto, bloqueado;
  logic [3:0] progresso;
  logic       A, B, C, D, E, F, G;
  logic [13:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  fechadura_param #(.N_DIGITOS(N), .CODIGO(COD), .MAX_ERROS(MAXE), .LOCK_CICLOS(L)) dut (
    .clk(clk), .reset(reset), .insere(insere), .numero(numero), .fechar(fechar), .prog(prog),
    .LED(LED), .aberto(aberto), .bloqueado(bloqueado), .progresso(progresso),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G)
  );

  always #5 clk = ~clk;
  assign obs = {LED, aberto, bloqueado, progresso, A, B, C, D, E, F, G};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;
      default: return DASH;
    endcase
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got LED/ab/bl/prog/seg=%b required %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic       ins;
    logic       fech;
    logic [3:0] num;
    logic       led;
    logic       ab;
    logic       bl;
    logic [3:0] pr;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[$];

  function automatic void row(input logic i, input logic f, input logic [3:0] n, input logic led,
                              input logic ab, input logic bl, input logic [3:0] pr, input logic [6:0] s);
    vec_t v;
    v.ins = i; v.fech = f; v.num = n; v.led = led; v.ab = ab; v.bl = bl; v.pr = pr; v.seg = s;
    vecs.push_back(v);
  endfunction

  // One strobe pulse followed by a release row with unchanged expectations.
  function automatic void pulse(input logic [3:0] n, input logic led, input logic ab, input logic bl,
                                input logic [3:0] pr, input logic [6:0] s);
    row(1'b1, 1'b0, n, led, ab, bl, pr, s);
    row(1'b0, 1'b0, n, led, ab, bl, pr, s);
  endfunction

  task automatic cyc(input logic i, input logic [3:0] n, input logic f);
    @(negedge clk);
    insere = i; numero = n; fechar = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; insere = 1'b0; fechar = 1'b0; prog = 1'b0; numero = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model: mode 0 waiting, 1 open, 2 locked out, 3 programming.
  int         m_mode, m_pos, m_errs, m_left;
  int         m_code[N];
  logic [6:0] m_disp;
  bit         m_ins_prev;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_errs = 0; m_left = 0; m_disp = BLANK; m_ins_prev = 1'b0;
    for (int i = 0; i < N; i++) m_code[i] = int'((COD >> (4 * (N - 1 - i))) & 24'hF);
  endfunction

  function automatic bit model_step(input bit ins, input int num, input bit fech, input bit pr);
    bit ev;
    ev = ins && !m_ins_prev;
    m_ins_prev = ins;
    if (m_mode == 0) begin
      if (ev) begin
        if (PROG_EN && pr && m_pos == 0 && m_errs == 0) begin
          m_mode = 3; m_code[0] = num; m_pos = 1; m_disp = seg_of(num);
        end else if (num == m_code[m_pos]) begin
          m_disp = seg_of(num);
          if (m_pos == N - 1) m_mode = 1; else m_pos++;
        end else if (m_errs < MAXE) begin
          m_errs++; m_disp = seg_of(num);
        end else begin
          m_mode = 2; m_left = L;
        end
      end
    end else if (m_mode == 1) begin
      if (fech) begin m_mode = 0; m_pos = 0; m_errs = 0; m_disp = BLANK; end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) begin m_mode = 0; m_pos = 0; m_errs = 0; m_disp = BLANK; end
    end else begin
      if (ev) begin
        m_code[m_pos] = num; m_disp = seg_of(num);
        if (m_pos == N - 1) begin m_mode = 0; m_pos = 0; end else m_pos++;
      end
    end
    return ev;
  endfunction

  function automatic logic [13:0] model_exp();
    logic [6:0] s;
    s = (m_mode == 1) ? SA : (m_mode == 2) ? SF : m_disp;
    return {m_errs != 0, m_mode == 1, m_mode == 2, 4'(m_pos), s};
  endfunction

  initial begin
    int cnt;
    int d_ok[5];
    int d_er[4];
    reset = 1'b1; insere = 1'b0; fechar = 1'b0; prog = 1'b0; numero = 4'd0;

    // Vector table: correct entry, entry with one tolerated error, fechar+strobe in ABERTO.
    d_ok = '{5, 9, 0, 9, 8};
    for (int k = 0; k < 5; k++) pulse(4'(d_ok[k]), 0, 0, 0, 4'(k + 1), seg_of(d_ok[k]));
    pulse(4'd1, 0, 1, 0, 4'd5, SA);
    pulse(4'd7, 0, 1, 0, 4'd5, SA);
    row(1'b0, 1'b1, 4'd0, 0, 0, 0, 4'd0, BLANK);
    pulse(4'd5, 0, 0, 0, 4'd1, seg_of(5));
    pulse(4'd3, 1, 0, 0, 4'd1, seg_of(3));
    d_er = '{9, 0, 9, 8};
    for (int k = 0; k < 4; k++) pulse(4'(d_er[k]), 1, 0, 0, 4'(k + 2), seg_of(d_er[k]));
    pulse(4'd1, 1, 1, 0, 4'd5, SA);
    row(1'b1, 1'b1, 4'd4, 0, 0, 0, 4'd0, BLANK);
    row(1'b0, 1'b0, 4'd4, 0, 0, 0, 4'd0, BLANK);
    pulse(4'd5, 0, 0, 0, 4'd1, seg_of(5));
    pulse(4'd12, 1, 0, 0, 4'd1, DASH);
    pulse(4'd9, 1, 0, 0, 4'd2, seg_of(9));

    @(posedge clk);
    #1;
    check("reset_state", obs, {3'b000, 4'd0, BLANK});
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].ins, vecs[i].num, vecs[i].fech);
      check($sformatf("vec%0d", i), obs,
            {vecs[i].led, vecs[i].ab, vecs[i].bl, vecs[i].pr, vecs[i].seg});
      $display("[TB] vec %0d ins=%0d fech=%0d num=%0d -> %b", i, vecs[i].ins, vecs[i].fech, vecs[i].num, obs);
    end

    // Lockout: exact duration, strobes ignored, strobe coinciding with expiry ignored.
    do_reset();
    cyc(1, 4'd5, 0); cyc(0, 4'd5, 0);
    cyc(1, 4'd3, 0); cyc(0, 4'd3, 0);
    cyc(1, 4'd7, 0);
    check("lock_entry", {bloqueado, A, B, C, D, E, F, G}, {1'b1, SF});
    cnt = 1;
    for (int j = 0; j < 1100; j++) begin
      cyc(logic'(j % 2), 4'd5, 1'b0);
      if (!bloqueado) break;
      cnt++;
    end
    $display("[TB] lockout lasted %0d cycles", cnt);
    check("lock_cycles", 14'(cnt), 14'(L));
    check("lock_exit", obs, {3'b000, 4'd0, BLANK});

    // Held strobe gives exactly one entry; async reset clears outputs before any clock edge.
    do_reset();
    for (int j = 0; j < 20; j++) cyc(1, 4'd5, 0);
    check("hold_one_ev", obs, {3'b000, 4'd1, seg_of(5)});
    cyc(0, 4'd9, 0); cyc(1, 4'd9, 0);
    check("hold_next", obs, {3'b000, 4'd2, seg_of(9)});
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset", obs, {3'b000, 4'd0, BLANK});
    $display("[TB] async reset at t=%0t -> %b", $time, obs);
    @(negedge clk);
    reset = 1'b0; insere = 1'b0;

`ifdef FECHADURA_PROG_EN
    do_reset();
    prog = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 4'(k), 0); cyc(0, 4'(k), 0);
      prog = 1'b0;
    end
    check("prog_done", obs, {3'b000, 4'd0, seg_of(6)});
    for (int k = 1; k <= 6; k++) begin cyc(1, 4'(k), 0); cyc(0, 4'(k), 0); end
    check("prog_open", obs, {3'b010, 4'd5, SA});
    cyc(0, 4'd0, 1);
    cyc(0, 4'd0, 0);
    cyc(1, 4'd5, 0); cyc(0, 4'd5, 0);
    check("prog_old1", obs, {3'b100, 4'd0, seg_of(5)});
    cyc(1, 4'd9, 0); cyc(0, 4'd9, 0);
    check("prog_old2", obs, {3'b101, 4'd0, SF});
`endif

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 6000; c++) begin
      logic       r_ins, r_fech, r_prog;
      logic [3:0] r_num;
      bit         ev;
      r_ins  = logic'($urandom_range(0, 1));
      r_fech = ($urandom_range(0, 7) == 0);
      r_prog = PROG_EN ? ($urandom_range(0, 19) == 0) : logic'($urandom_range(0, 1));
      if (m_mode == 0 && $urandom_range(0, 9) < 8) r_num = 4'(m_code[m_pos]);
      else r_num = 4'($urandom_range(0, 15));
      @(negedge clk);
      insere = r_ins; numero = r_num; fechar = r_fech; prog = r_prog;
      @(posedge clk);
      ev = model_step(r_ins, int'(r_num), r_fech, r_prog);
      #1;
      check($sformatf("rand%0d", c), obs, model_exp());
      if (ev) $display("[TB] rand cycle %0d ev num=%0d -> %b", c, r_num, obs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
